led_seq_responder: RTL and testbench
====================================

Name: led_seq_responder

Overview:
- Pattern-step responder: the responder side of the begin/over handshake that the mode sequencers use to run sub-patterns on the 18-LED red bank.
- On a begin level from the sequencer's state chooser, it plays one parameterised LED pattern frame-by-frame on the divided clock.
- On the last frame it pulses over so the sequencer advances to its next state.
- Instantiated once per sub-state; its output goes to the LED chooser mux.

Parameters:
- WIDTH, 18: LED bank width; must be even and >= 4.
- PATTERN, 0: 0 = fill-left, 1 = fill-right, 2 = blink, 3 = converge.
- REPEAT, 1: number of full pattern passes before over; must be >= 1.
- BLINK_CYCLES, 4: on/off pairs per pass in blink mode; must be >= 1.

Ports:
- clk  input  1  divided LED step clock; all state changes on its rising edge.
- async_rs  input  1  reset, asynchronous assert, active-low.
- enabler  input  1  mode enable; low forces idle synchronously.
- st_begin  input  1  begin level from the sequencer; high while this sub-state is selected.
- out  output  WIDTH  LED frame.
- st_over  output  1  registered completion flag; high during the last frame only.

Behaviour:
- Reset (async_rs = 0): state IDLE, out = 0, st_over = 0, frame counter = 0, pass counter = 0. Effective immediately, independent of clk.
- Frame counter: $clog2(max N)+1 bits. Pass counter: $clog2(REPEAT)+1 bits.
- FSM states:
  - IDLE: out = 0, st_over = 0. If enabler & st_begin at an edge, go to RUN with frame k = 0, pass p = 0, and load frame 0 into out at that same edge. One-cycle latency from begin to first lit frame.
  - RUN: each edge loads frame k+1. At k = N-1, wrap to k = 0 and increment p.
    - Combined end frame: frame N-1 of pass REPEAT-1. st_over = 1 for exactly the cycle this frame is displayed. At the following edge, go to DONE, out = 0, st_over = 0.
  - DONE: out = 0, st_over = 0. Stay until st_begin = 0, then go to IDLE. A held begin never retriggers.
- Frame definitions, k = 0..N-1:
  - fill-left: N = WIDTH; out = bits [k:0] set.
  - fill-right: N = WIDTH; out = bits [WIDTH-1:WIDTH-1-k] set.
  - blink: N = 2*BLINK_CYCLES; even k = all ones, odd k = all zeros.
  - converge: N = WIDTH/2; bits [k:0] and [WIDTH-1:WIDTH-1-k] set. Last frame is all ones.
- Boundary conditions:
  - st_begin falls during RUN: abort to IDLE at that edge; out = 0, no st_over.
  - enabler = 0 in any state: next edge goes to IDLE, out = 0, st_over = 0. Takes priority over all other transitions.
  - st_begin = 1 in the cycle st_over is high: the sequencer advances on the same edge. The responder goes to DONE regardless.
  - Reset asserted mid-RUN or while st_over = 1: immediate clear; st_over never glitches high after reset release.
  - Counters wrap only as defined. No out-of-range k is ever displayed.

Test Plan:
- Reset with st_begin = 1, enabler = 1, then release async_rs. Fill-left, WIDTH = 18, REPEAT = 1:
  - out = 0x00001 one edge after release.
  - Then 0x00003, 0x00007, … up to 0x3FFFF.
  - st_over = 1 only during the 0x3FFFF cycle, 18 cycles total.
  - Then out = 0, in DONE.
- Blink, BLINK_CYCLES = 2, REPEAT = 2:
  - out sequence 3FFFF, 0, 3FFFF, 0, repeated twice.
  - st_over high only on the 8th frame (out = 0).
- Converge, WIDTH = 18:
  - Frames 0x20001, 0x30003, … up to 0x3FFFF.
  - st_over high on the 9th frame.
- Drop st_begin at frame 5 of fill-right:
  - Next edge out = 0, state IDLE, st_over never asserted.
  - Re-assert st_begin: restarts at 0x20000.
- Hold st_begin = 1 after st_over:
  - out stays 0 in DONE.
  - No restart until st_begin goes 0 then 1.
- enabler = 0 mid-RUN: next edge out = 0. Assert async_rs = 0 while st_over = 1: out and st_over clear immediately, without a clock edge.

Source files
------------

// File: rtl/led_seq_responder.sv
// Begin/over responder: plays one LED pattern frame-by-frame on the step clock
// and flags the final frame so the mode sequencer can advance.
//
// state | meaning
// IDLE  | dark, waiting for enabler & st_begin
// RUN   | displaying frame r_k of pass r_p
// DONE  | pattern finished, dark until st_begin drops
module led_seq_responder #(
    parameter int WIDTH        = 18,
    parameter int PATTERN      = 0,
    parameter int REPEAT       = 1,
    parameter int BLINK_CYCLES = 4
) (
    input  logic             clk,
    input  logic             async_rs,
    input  logic             enabler,
    input  logic             st_begin,
    output logic [WIDTH-1:0] out,
    output logic             st_over
);

    localparam int N    = (PATTERN == 2) ? 2 * BLINK_CYCLES :
                          (PATTERN == 3) ? WIDTH / 2 : WIDTH;
    localparam int MAXN = (WIDTH > 2 * BLINK_CYCLES) ? WIDTH : 2 * BLINK_CYCLES;
    localparam int KW   = $clog2(MAXN) + 1;
    localparam int PW   = $clog2(REPEAT) + 1;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [PW-1:0] P_LAST = PW'(REPEAT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [KW-1:0]    r_k;
    logic [PW-1:0]    r_p;
    logic [WIDTH-1:0] r_out;
    logic             r_over;

    logic [1:0]       w_state_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic [PW-1:0]    w_p_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_over_nxt;
    logic             w_wrap;
    logic [KW-1:0]    w_k_adv;
    logic [PW-1:0]    w_p_adv;

    function automatic logic [WIDTH-1:0] frame(input logic [KW-1:0] k);
        logic [WIDTH-1:0] f;
        f = '0;
        if (PATTERN == 2) begin
            f = k[0] ? '0 : '1;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (PATTERN == 1)
                    f[i] = (i >= WIDTH - 1 - int'(k));
                else if (PATTERN == 3)
                    f[i] = (i <= int'(k)) || (i >= WIDTH - 1 - int'(k));
                else
                    f[i] = (i <= int'(k));
            end
        end
        return f;
    endfunction

    assign w_wrap  = (r_k == K_LAST);
    assign w_k_adv = w_wrap ? '0 : r_k + KW'(1);
    assign w_p_adv = w_wrap ? r_p + PW'(1) : r_p;

    // Outputs are computed for the frame being entered so out/st_over stay registered.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_p_nxt     = r_p;
        w_out_nxt   = '0;
        w_over_nxt  = 1'b0;
        if (!enabler) begin
            w_state_nxt = IDLE;
            w_k_nxt     = '0;
            w_p_nxt     = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (st_begin) begin
                        w_state_nxt = RUN;
                        w_k_nxt     = '0;
                        w_p_nxt     = '0;
                        w_out_nxt   = frame('0);
                        w_over_nxt  = (K_LAST == '0) && (P_LAST == '0);
                    end
                end
                RUN: begin
                    if (!st_begin || r_over) begin
                        w_state_nxt = st_begin ? DONE : IDLE;
                        w_k_nxt     = '0;
                        w_p_nxt     = '0;
                    end else begin
                        w_k_nxt    = w_k_adv;
                        w_p_nxt    = w_p_adv;
                        w_out_nxt  = frame(w_k_adv);
                        w_over_nxt = (w_k_adv == K_LAST) && (w_p_adv == P_LAST);
                    end
                end
                DONE: begin
                    if (!st_begin)
                        w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_k_nxt     = '0;
                    w_p_nxt     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rs) begin
        if (!async_rs) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_p     <= '0;
            r_out   <= '0;
            r_over  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_p     <= w_p_nxt;
            r_out   <= w_out_nxt;
            r_over  <= w_over_nxt;
        end
    end

    assign out     = r_out;
    assign st_over = r_over;

endmodule

// File: tb/tb_led_seq_responder.sv
// Directed bench for led_seq_responder: one instance per pattern flavour,
// expected frames computed from closed-form masks.
module tb_led_seq_responder;

    logic        clk = 1'b0;
    logic        async_rs = 1'b0;
    logic        enabler = 1'b1;
    logic        beg_l = 1'b0, beg_r = 1'b0, beg_b = 1'b0, beg_c = 1'b0;
    logic [17:0] out_l, out_r, out_b, out_c;
    logic        ovr_l, ovr_r, ovr_b, ovr_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_seq_responder #(.WIDTH(18), .PATTERN(0), .REPEAT(1), .BLINK_CYCLES(4)) u_left (
        .clk(clk), .async_rs(async_rs), .enabler(enabler), .st_begin(beg_l),
        .out(out_l), .st_over(ovr_l));
    led_seq_responder #(.WIDTH(18), .PATTERN(1), .REPEAT(1), .BLINK_CYCLES(4)) u_right (
        .clk(clk), .async_rs(async_rs), .enabler(enabler), .st_begin(beg_r),
        .out(out_r), .st_over(ovr_r));
    led_seq_responder #(.WIDTH(18), .PATTERN(2), .REPEAT(2), .BLINK_CYCLES(2)) u_blink (
        .clk(clk), .async_rs(async_rs), .enabler(enabler), .st_begin(beg_b),
        .out(out_b), .st_over(ovr_b));
    led_seq_responder #(.WIDTH(18), .PATTERN(3), .REPEAT(1), .BLINK_CYCLES(4)) u_conv (
        .clk(clk), .async_rs(async_rs), .enabler(enabler), .st_begin(beg_c),
        .out(out_c), .st_over(ovr_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] low_mask(input int k);
        return (32'd1 << (k + 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] high_mask(input int k);
        return (low_mask(k) << (17 - k)) & 32'h3FFFF;
    endfunction

    initial begin
        // Fill-left from reset with begin already high.
        beg_l = 1'b1;
        tick;
        chk("reset_out", 32'(out_l), 32'h0);
        chk("reset_over", 32'(ovr_l), 32'h0);
        async_rs = 1'b1;
        for (int k = 0; k < 18; k++) begin
            tick;
            chk("fl_out", 32'(out_l), low_mask(k));
            chk("fl_over", 32'(ovr_l), (k == 17) ? 32'h1 : 32'h0);
        end
        tick;
        chk("fl_done_out", 32'(out_l), 32'h0);
        chk("fl_done_over", 32'(ovr_l), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("fl_hold_out", 32'(out_l), 32'h0);
        end
        beg_l = 1'b0;
        tick;
        chk("fl_idle_out", 32'(out_l), 32'h0);
        beg_l = 1'b1;
        tick;
        chk("fl_restart", 32'(out_l), 32'h1);
        beg_l = 1'b0;
        tick;
        chk("fl_abort", 32'(out_l), 32'h0);

        // Blink, two on/off pairs per pass, two passes.
        beg_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk("bl_out", 32'(out_b), (k % 2 == 0) ? 32'h3FFFF : 32'h0);
            chk("bl_over", 32'(ovr_b), (k == 7) ? 32'h1 : 32'h0);
        end
        tick;
        chk("bl_done_over", 32'(ovr_b), 32'h0);
        beg_b = 1'b0;
        tick;

        // Converge.
        beg_c = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick;
            chk("cv_out", 32'(out_c), low_mask(k) | high_mask(k));
            chk("cv_over", 32'(ovr_c), (k == 8) ? 32'h1 : 32'h0);
        end
        tick;
        chk("cv_done_out", 32'(out_c), 32'h0);
        beg_c = 1'b0;
        tick;

        // Fill-right aborted at frame 5, then restarted.
        beg_r = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("fr_out", 32'(out_r), high_mask(k));
            chk("fr_over", 32'(ovr_r), 32'h0);
        end
        beg_r = 1'b0;
        tick;
        chk("fr_abort_out", 32'(out_r), 32'h0);
        chk("fr_abort_over", 32'(ovr_r), 32'h0);
        beg_r = 1'b1;
        tick;
        chk("fr_restart", 32'(out_r), 32'h20000);
        beg_r = 1'b0;
        tick;

        // Enabler low mid-run.
        beg_l = 1'b1;
        for (int k = 0; k < 4; k++) tick;
        chk("en_pre", 32'(out_l), low_mask(3));
        enabler = 1'b0;
        tick;
        chk("en_off_out", 32'(out_l), 32'h0);
        chk("en_off_over", 32'(ovr_l), 32'h0);
        beg_l = 1'b0;
        tick;
        enabler = 1'b1;
        tick;

        // Async reset while st_over is high.
        beg_l = 1'b1;
        for (int k = 0; k < 18; k++) tick;
        chk("rs_pre_over", 32'(ovr_l), 32'h1);
        async_rs = 1'b0;
        #1;
        chk("rs_async_out", 32'(out_l), 32'h0);
        chk("rs_async_over", 32'(ovr_l), 32'h0);
        beg_l = 1'b0;
        tick;
        async_rs = 1'b1;
        tick;
        chk("rs_release_over", 32'(ovr_l), 32'h0);
        chk("rs_release_out", 32'(out_l), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
